// File: rtl/req_arbiter.sv
// ============================================================================
//  Module   : req_arbiter
//  Brief    : Eight-requester arbiter with fixed-priority (bit 7 highest) and
//             round-robin modes. A grant is held until the owner drops its
//             request or, when MAX_HOLD is non-zero, until MAX_HOLD cycles
//             have elapsed. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module req_arbiter #(
  parameter int MAX_HOLD = 16   // 1..255 cycles, 0 = unlimited
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rr_en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Hold counter value on which a grant is force-released. For MAX_HOLD = 0
  // this evaluates to 255 but is never used because HOLD_EN is clear.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam bit         HOLD_EN   = (MAX_HOLD != 0);

  state_t     state_q;
  logic [7:0] gnt_q;
  logic [2:0] gnt_id_q;
  logic       gnt_valid_q;
  logic       timeout_q;
  logic [2:0] last_q;
  logic [7:0] hold_q;

  logic [2:0] fixed_id_d;
  logic [2:0] rr_id_d;
  logic [2:0] win_id_d;

  // Winner selection: highest set bit for fixed mode; for round-robin the
  // search runs last-1, last-2, ..., last (mod 8). The loop runs from the
  // lowest-priority offset upward so the highest-priority match is assigned
  // last and wins.
  always_comb begin
    fixed_id_d = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) fixed_id_d = 3'(i);
    end
    rr_id_d = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (req[last_q - 3'(k)]) rr_id_d = last_q - 3'(k);
    end
    win_id_d = rr_en ? rr_id_d : fixed_id_d;
  end

  // Grant state machine; every output is a register so nothing from req
  // reaches gnt combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 8'd0;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= 3'd0;
      hold_q      <= 8'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            state_q     <= S_GRANT;
            gnt_q       <= 8'd1 << win_id_d;
            gnt_id_q    <= win_id_d;
            gnt_valid_q <= 1'b1;
            last_q      <= win_id_d;
            hold_q      <= 8'd0;
          end
        end
        S_GRANT: begin
          if (!req[gnt_id_q]) begin
            state_q     <= S_IDLE;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
          end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
            state_q     <= S_IDLE;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
          end else if (hold_q != 8'hFF) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          gnt_q       <= 8'd0;
          gnt_id_q    <= 3'd0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter.sv
// ============================================================================
//  Module   : tb_req_arbiter
//  Brief    : Directed self-checking bench for req_arbiter. Four instances
//             with different MAX_HOLD values share the stimulus; each scenario
//             checks the instance it targets.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rr_en;

  logic [7:0] gnt_16, gnt_0, gnt_4, gnt_3;
  logic [2:0] id_16, id_0, id_4, id_3;
  logic       vld_16, vld_0, vld_4, vld_3;
  logic       to_16, to_0, to_4, to_3;

  int n_chk;
  int n_err;

  req_arbiter #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .gnt(gnt_16), .gnt_id(id_16), .gnt_valid(vld_16), .timeout(to_16));

  req_arbiter #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .gnt(gnt_0), .gnt_id(id_0), .gnt_valid(vld_0), .timeout(to_0));

  req_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .gnt(gnt_4), .gnt_id(id_4), .gnt_valid(vld_4), .timeout(to_4));

  req_arbiter #(.MAX_HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
    .gnt(gnt_3), .gnt_id(id_3), .gnt_valid(vld_3), .timeout(to_3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    req   = 8'd0;
    rr_en = 1'b0;
    rst_n = 1'b1;
    do_reset();

    // Reset state
    chk("rst_gnt",   gnt_16, 8'd0);
    chk("rst_id",    id_16,  3'd0);
    chk("rst_vld",   vld_16, 1'b0);
    chk("rst_to",    to_16,  1'b0);

    // Fixed priority: 5 beats 2, then 2 after one idle cycle
    rr_en = 1'b0;
    req   = 8'b0010_0100;
    tick();
    chk("fx_gnt5",   gnt_16, 8'b0010_0000);
    chk("fx_id5",    id_16,  3'd5);
    chk("fx_vld5",   vld_16, 1'b1);
    tick();
    chk("fx_hold5",  gnt_16, 8'b0010_0000);
    req = 8'b0000_0100;
    tick();
    chk("fx_idle",   gnt_16, 8'd0);
    chk("fx_idle_id", id_16, 3'd0);
    chk("fx_idle_v", vld_16, 1'b0);
    tick();
    chk("fx_gnt2",   gnt_16, 8'b0000_0100);
    chk("fx_id2",    id_16,  3'd2);

    // Mode change mid-grant: grant persists, next RR search starts at 1
    rr_en = 1'b1;
    req   = 8'b1000_0110;
    tick();
    chk("mc_keep2",  id_16,  3'd2);
    chk("mc_keepg",  gnt_16, 8'b0000_0100);
    req = 8'b1000_0010;
    tick();
    chk("mc_idle",   vld_16, 1'b0);
    tick();
    chk("mc_rr1",    id_16,  3'd1);
    chk("mc_rr1g",   gnt_16, 8'b0000_0010);

    // Async reset mid-grant, then RR pointer must restart from 7
    req   = 8'd0;
    rr_en = 1'b0;
    tick();
    tick();
    req = 8'b0100_0000;
    tick();
    chk("ar_id6",    id_16,  3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt",    gnt_16, 8'd0);
    chk("ar_vld",    vld_16, 1'b0);
    chk("ar_id",     id_16,  3'd0);
    req   = 8'hFF;
    rr_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_first7", id_16,  3'd7);
    chk("ar_firstg", gnt_16, 8'b1000_0000);

    // Round-robin fairness with unlimited hold
    do_reset();
    rr_en = 1'b1;
    req   = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      logic [2:0] exp_id;
      exp_id = 3'(7 - (g % 8));
      chk($sformatf("rr_id%0d", g),  id_0,  exp_id);
      chk($sformatf("rr_g%0d", g),   gnt_0, 8'd1 << exp_id);
      tick();
      chk($sformatf("rr_hold%0d", g), id_0, exp_id);
      req = 8'hFF & ~(8'd1 << exp_id);
      tick();
      chk($sformatf("rr_idle%0d", g), vld_0, 1'b0);
      chk($sformatf("rr_to%0d", g),   to_0,  1'b0);
      req = 8'hFF;
      tick();
    end

    // Timeout with MAX_HOLD = 4
    do_reset();
    rr_en = 1'b0;
    req   = 8'b0000_1000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("to4_g%0d", c),  gnt_4, 8'b0000_1000);
      chk($sformatf("to4_t%0d", c),  to_4,  1'b0);
    end
    tick();
    chk("to4_rel",   gnt_4, 8'd0);
    chk("to4_pulse", to_4,  1'b1);
    tick();
    chk("to4_regnt", gnt_4, 8'b0000_1000);
    chk("to4_id",    id_4,  3'd3);
    chk("to4_tclr",  to_4,  1'b0);

    // Timeout with MAX_HOLD = 3 in RR (alternates) and fixed (always 7)
    for (int m = 0; m < 2; m++) begin
      do_reset();
      rr_en = (m == 0);
      req   = 8'b1000_0001;
      tick();
      for (int g = 0; g < 4; g++) begin
        logic [2:0] exp_id;
        exp_id = (m == 0 && (g % 2) == 1) ? 3'd0 : 3'd7;
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("to3_m%0d_g%0d_c%0d", m, g, c), id_3,  exp_id);
          chk($sformatf("to3_v_m%0d_g%0d_c%0d", m, g, c), vld_3, 1'b1);
          tick();
        end
        chk($sformatf("to3_rel_m%0d_g%0d", m, g), vld_3, 1'b0);
        chk($sformatf("to3_to_m%0d_g%0d", m, g),  to_3,  1'b1);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
